// File: rtl/rob_id_remap_alloc.sv
// rob_id_remap_alloc: binds each AXI ID to a table row and hands out successive
// columns of that row, so every outstanding read gets unique_id = {row, col}.
// Requests use a valid/ready handshake, and retires free the oldest column of a row.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset (0 = reset)
//   alloc_valid/id    allocation request; alloc_ready is combinational accept
//   grant_valid/uid   one-cycle grant the cycle after accept, {row, col}
//   grant_id          echo of accepted alloc_id
//   free_valid/row    retire the oldest outstanding entry of free_row
//   free_err          one-cycle pulse when a free hits an empty row
//   rows_used         number of bound rows; table_full when all rows bound
module rob_id_remap_alloc #(
  parameter int unsigned ID_WIDTH = 4,
  parameter int unsigned NUM_ROWS = 16,
  parameter int unsigned NUM_COLS = 16
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           alloc_valid,
  input  logic [ID_WIDTH-1:0]                            alloc_id,
  output logic                                           alloc_ready,
  output logic                                           grant_valid,
  output logic [$clog2(NUM_ROWS)+$clog2(NUM_COLS)-1:0]   grant_uid,
  output logic [ID_WIDTH-1:0]                            grant_id,
  input  logic                                           free_valid,
  input  logic [$clog2(NUM_ROWS)-1:0]                    free_row,
  output logic                                           free_err,
  output logic [$clog2(NUM_ROWS):0]                      rows_used,
  output logic                                           table_full
);

  localparam int unsigned ROW_W = $clog2(NUM_ROWS);
  localparam int unsigned COL_W = $clog2(NUM_COLS);
  localparam int unsigned CNT_W = COL_W + 1;
  localparam int unsigned USE_W = ROW_W + 1;

  // Per-row state
  logic                bound_q  [NUM_ROWS];
  logic [ID_WIDTH-1:0] id_q     [NUM_ROWS];
  logic [COL_W-1:0]    wr_col_q [NUM_ROWS];
  logic [COL_W-1:0]    rd_col_q [NUM_ROWS];
  logic [CNT_W-1:0]    count_q  [NUM_ROWS];

  logic             hit;
  logic [ROW_W-1:0] hit_row;
  logic             any_unbound;
  logic [ROW_W-1:0] unbound_row;
  logic [ROW_W-1:0] tgt_row;
  logic             fire;
  logic             free_ok;
  logic             bind_new;
  logic             unbind;
  logic [NUM_ROWS-1:0] fire_vec;
  logic [NUM_ROWS-1:0] free_vec;
  logic [USE_W-1:0] rows_used_nxt;

  // ID lookup: matching bound row, and lowest-index unbound row as miss target
  always_comb begin
    hit         = 1'b0;
    hit_row     = '0;
    any_unbound = 1'b0;
    unbound_row = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (bound_q[r] && (id_q[r] == alloc_id) && !hit) begin
        hit     = 1'b1;
        hit_row = ROW_W'(r);
      end
      if (!bound_q[r] && !any_unbound) begin
        any_unbound = 1'b1;
        unbound_row = ROW_W'(r);
      end
    end
  end

  // Accept/retire decode; everything is derived from pre-update state
  always_comb begin
    tgt_row     = hit ? hit_row : unbound_row;
    alloc_ready = rst && (hit ? (count_q[hit_row] < CNT_W'(NUM_COLS)) : any_unbound);
    fire        = alloc_valid && alloc_ready;
    bind_new    = fire && !hit;
    free_ok     = free_valid && (count_q[free_row] != '0);
    // A same-cycle fire on the row being drained keeps it bound
    unbind      = free_ok && (count_q[free_row] == CNT_W'(1)) &&
                  !(fire && (tgt_row == free_row));
    fire_vec    = '0;
    free_vec    = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      fire_vec[r] = fire && (tgt_row == ROW_W'(r));
      free_vec[r] = free_ok && (free_row == ROW_W'(r));
    end
    rows_used_nxt = rows_used;
    if (bind_new && !unbind) begin
      rows_used_nxt = rows_used + USE_W'(1);
    end else if (unbind && !bind_new) begin
      rows_used_nxt = rows_used - USE_W'(1);
    end
  end

  // Row table update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        bound_q[r]  <= 1'b0;
        id_q[r]     <= '0;
        wr_col_q[r] <= '0;
        rd_col_q[r] <= '0;
        count_q[r]  <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (fire_vec[r]) begin
          wr_col_q[r] <= wr_col_q[r] + COL_W'(1);
          if (bind_new) begin
            bound_q[r] <= 1'b1;
            id_q[r]    <= alloc_id;
          end
        end
        if (free_vec[r]) begin
          rd_col_q[r] <= rd_col_q[r] + COL_W'(1);
        end
        if (fire_vec[r] && !free_vec[r]) begin
          count_q[r] <= count_q[r] + CNT_W'(1);
        end else if (free_vec[r] && !fire_vec[r]) begin
          count_q[r] <= count_q[r] - CNT_W'(1);
          // Column pointers survive unbind so reused rows never alias stale tags
          if (count_q[r] == CNT_W'(1)) begin
            bound_q[r] <= 1'b0;
            id_q[r]    <= '0;
          end
        end
      end
    end
  end

  // Registered grant, error and occupancy outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_valid <= 1'b0;
      grant_uid   <= '0;
      grant_id    <= '0;
      free_err    <= 1'b0;
      rows_used   <= '0;
      table_full  <= 1'b0;
    end else begin
      grant_valid <= fire;
      if (fire) begin
        grant_uid <= {tgt_row, wr_col_q[tgt_row]};
        grant_id  <= alloc_id;
      end
      free_err   <= free_valid && !free_ok;
      rows_used  <= rows_used_nxt;
      table_full <= (rows_used_nxt == USE_W'(NUM_ROWS));
    end
  end

endmodule
